// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the gate sweep controller: FSM encoding and legal
// parameter ranges.
package gate_sweep_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StSample = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned NInMin    = 1;
  localparam int unsigned NInMax    = 4;
  localparam int unsigned SettleMin = 1;
  localparam int unsigned SettleMax = 15;

endpackage

// File: rtl/gate_sweep_controller.sv
// Exhaustive truth-table sweep of a small combinational gate: steps every input
// vector, samples the gate after a settle time and reports mismatches.
module gate_sweep_controller
  import gate_sweep_pkg::*;
#(
  parameter int unsigned N_IN   = 1,
  parameter int unsigned SETTLE = 1,
  localparam int unsigned NV    = 2 ** N_IN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [NV-1:0]   exp_tt,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  if (N_IN < NInMin || N_IN > NInMax) begin : gen_bad_n_in
    $error("gate_sweep_controller: N_IN out of range 1..4");
  end
  if (SETTLE < SettleMin || SETTLE > SettleMax) begin : gen_bad_settle
    $error("gate_sweep_controller: SETTLE out of range 1..15");
  end

  localparam logic [3:0] CntLoad = 4'(SETTLE - 1);

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [N_IN-1:0] vec_q;
  logic [NV-1:0]   exp_q;
  logic            busy_q, done_q, pass_q;
  logic [N_IN:0]   err_q;
  logic [N_IN-1:0] ff_q;

  logic            mismatch;
  logic            last_vec;
  logic [N_IN:0]   err_next;

  // dut_out is only meaningful in SAMPLE; these are ignored elsewhere.
  always_comb begin
    mismatch = (dut_out != exp_q[vec_q]);
    last_vec = (vec_q == '1);
    err_next = err_q + {{N_IN{1'b0}}, mismatch};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      vec_q   <= '0;
      exp_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            exp_q   <= exp_tt;
            vec_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            pass_q  <= 1'b0;
            cnt_q   <= CntLoad;
            busy_q  <= 1'b1;
            state_q <= StSettle;
          end
        end
        StSettle: begin
          if (cnt_q == '0) begin
            state_q <= StSample;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StSample: begin
          err_q <= err_next;
          if (mismatch && err_q == '0) begin
            ff_q <= vec_q;
          end
          if (last_vec) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            // Publish pass together with done so it already includes the last vector.
            pass_q  <= (err_next == '0);
            state_q <= StDone;
          end else begin
            vec_q   <= vec_q + 1'b1;
            cnt_q   <= CntLoad;
            state_q <= StSettle;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dut_in     = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Bench for gate_sweep_controller: three configurations, random truth tables,
// scoreboard of expected runs checked cycle by cycle by a monitor.
module tb_gate_sweep_controller;

  localparam int NDUT = 3;
  localparam int NI [NDUT] = '{1, 2, 3};
  localparam int SI [NDUT] = '{1, 3, 2};

  typedef struct {
    int acc;    // cycle index of the acceptance edge
    int abort;  // cycle index of a reset edge, or -1
    int err;
    int ff;
    int pass;
  } sb_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        start_a  [NDUT];
  logic        rst_a    [NDUT];
  logic        busy_a   [NDUT];
  logic        done_a   [NDUT];
  logic        pass_a   [NDUT];
  logic        gout_a   [NDUT];
  logic [15:0] exp_tt_a [NDUT];
  logic [15:0] act_tt_a [NDUT];
  logic [3:0]  din_a    [NDUT];
  logic [3:0]  ff_a     [NDUT];
  logic [4:0]  err_a    [NDUT];

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int N  = NI[g];
    localparam int S  = SI[g];
    localparam int NV = 1 << N;
    logic [N-1:0] din;
    logic [N:0]   err;
    logic [N-1:0] ff;

    gate_sweep_controller #(.N_IN(N), .SETTLE(S)) u_dut (
      .clk        (clk),
      .rst        (rst_a[g]),
      .start      (start_a[g]),
      .exp_tt     (exp_tt_a[g][NV-1:0]),
      .dut_in     (din),
      .dut_out    (gout_a[g]),
      .busy       (busy_a[g]),
      .done       (done_a[g]),
      .pass       (pass_a[g]),
      .err_count  (err),
      .first_fail (ff)
    );

    // Gate under test: its real truth table is act_tt.
    assign gout_a[g] = act_tt_a[g][din];
    assign din_a[g]  = 4'(din);
    assign err_a[g]  = 5'(err);
    assign ff_a[g]   = 4'(ff);
  end

  sb_t  sb_q [NDUT][$];
  int   last_err  [NDUT];
  int   last_ff   [NDUT];
  int   last_pass [NDUT];
  bit   clean     [NDUT];
  bit   mon_en = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s dut%0d cyc=%0d got=%0h want=%0h", nm, d, cyc, got, want);
    end
  endtask

  task automatic check_idle(int d);
    chk("idle_busy", d, 32'(busy_a[d]), 0);
    chk("idle_done", d, 32'(done_a[d]), 0);
    chk("hold_err", d, 32'(err_a[d]), last_err[d]);
    chk("hold_ff", d, 32'(ff_a[d]), last_ff[d]);
    chk("hold_pass", d, 32'(pass_a[d]), last_pass[d]);
    if (clean[d]) chk("reset_din", d, 32'(din_a[d]), 0);
  endtask

  // Monitor: compares every DUT against the head of its scoreboard queue.
  always @(negedge clk) begin
    int  t;
    int  k;
    sb_t e;
    if (mon_en) begin
      for (int d = 0; d < NDUT; d++) begin
        t = (1 << NI[d]) * (SI[d] + 1);
        if (sb_q[d].size() == 0) begin
          check_idle(d);
        end else begin
          e = sb_q[d][0];
          if (e.abort >= 0 && cyc >= e.abort) begin
            chk("rst_busy", d, 32'(busy_a[d]), 0);
            chk("rst_done", d, 32'(done_a[d]), 0);
            chk("rst_din", d, 32'(din_a[d]), 0);
            chk("rst_err", d, 32'(err_a[d]), 0);
            chk("rst_ff", d, 32'(ff_a[d]), 0);
            chk("rst_pass", d, 32'(pass_a[d]), 0);
            last_err[d] = 0; last_ff[d] = 0; last_pass[d] = 0; clean[d] = 1'b1;
            void'(sb_q[d].pop_front());
          end else if (cyc < e.acc) begin
            check_idle(d);
          end else if (cyc < e.acc + t) begin
            k = cyc - e.acc;
            clean[d] = 1'b0;
            chk("run_busy", d, 32'(busy_a[d]), 1);
            chk("run_done", d, 32'(done_a[d]), 0);
            chk("run_din", d, 32'(din_a[d]), k / (SI[d] + 1));
            if (k == 0) begin
              chk("clr_err", d, 32'(err_a[d]), 0);
              chk("clr_ff", d, 32'(ff_a[d]), 0);
              chk("clr_pass", d, 32'(pass_a[d]), 0);
            end
          end else begin
            chk("end_done", d, 32'(done_a[d]), 1);
            chk("end_busy", d, 32'(busy_a[d]), 0);
            chk("end_err", d, 32'(err_a[d]), e.err);
            chk("end_ff", d, 32'(ff_a[d]), e.ff);
            chk("end_pass", d, 32'(pass_a[d]), e.pass);
            last_err[d] = e.err; last_ff[d] = e.ff; last_pass[d] = e.pass;
            void'(sb_q[d].pop_front());
          end
        end
      end
    end
  end

  // Expected result of one sweep, straight from the truth tables.
  function automatic sb_t model(int d, int acc, int abort, logic [15:0] ex, logic [15:0] ac);
    sb_t e;
    e.acc = acc; e.abort = abort; e.err = 0; e.ff = 0;
    for (int i = 0; i < (1 << NI[d]); i++) begin
      if (ex[i] !== ac[i]) begin
        if (e.err == 0) e.ff = i;
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    return e;
  endfunction

  // Called at posedge+1 with the DUT idle; returns after the acceptance edge.
  task automatic launch(int d, logic [15:0] ex, logic [15:0] ac, int abort_off);
    int acc;
    acc = cyc + 1;
    exp_tt_a[d] = ex;
    act_tt_a[d] = ac;
    start_a[d]  = 1'b1;
    sb_q[d].push_back(model(d, acc, (abort_off < 0) ? -1 : acc + abort_off, ex, ac));
    @(posedge clk); #1;
    start_a[d] = 1'b0;
  endtask

  task automatic wait_idle(int d);
    int n = 0;
    while (sb_q[d].size() != 0) begin
      @(posedge clk); #1;
      n++;
      if (n > 500) begin
        $display("FAIL wait_idle dut%0d scoreboard never drained", d);
        $fatal(1, "bench stuck");
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int          d;
    int          t;
    int          a;
    int          k;
    logic [15:0] ex;
    logic [15:0] ex2;
    logic [15:0] mask;

    for (int i = 0; i < NDUT; i++) begin
      start_a[i] = 1'b0; rst_a[i] = 1'b1;
      exp_tt_a[i] = '0; act_tt_a[i] = '0;
      last_err[i] = 0; last_ff[i] = 0; last_pass[i] = 0; clean[i] = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NDUT; i++) rst_a[i] = 1'b0;
    mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Inverter correct, inverter stuck-at-0.
    launch(0, 16'b01, 16'b01, -1); wait_idle(0);
    launch(0, 16'b01, 16'b00, -1); wait_idle(0);
    // 2-input AND, then AND miswired as OR.
    launch(1, 16'b1000, 16'b1000, -1); wait_idle(1);
    launch(1, 16'b1000, 16'b1110, -1); wait_idle(1);
    launch(2, 16'h0096, 16'h0096, -1); wait_idle(2);

    // Reset at edge 2 of a run, then a fresh run.
    launch(1, 16'b0110, 16'b1001, 2);
    @(posedge clk); #1;
    rst_a[1] = 1'b1;
    @(posedge clk); #1;
    rst_a[1] = 1'b0;
    wait_idle(1);
    launch(1, 16'b0110, 16'b0100, -1); wait_idle(1);

    // Start held high: two back-to-back runs, exp_tt changed during the first.
    for (int h = 0; h < NDUT; h++) begin
      t   = (1 << NI[h]) * (SI[h] + 1);
      ex  = 16'($urandom);
      ex2 = 16'($urandom);
      act_tt_a[h] = ex ^ 16'h0002;
      exp_tt_a[h] = ex;
      start_a[h]  = 1'b1;
      a = cyc + 1;
      sb_q[h].push_back(model(h, a, -1, ex, act_tt_a[h]));
      sb_q[h].push_back(model(h, a + t + 2, -1, ex2, act_tt_a[h]));
      @(posedge clk); #1;
      exp_tt_a[h] = ex2;
      repeat (t + 2) @(posedge clk);
      #1;
      start_a[h] = 1'b0;
      wait_idle(h);
    end

    // Random runs with stray start pulses and exp_tt changes mid-run.
    for (int r = 0; r < 40; r++) begin
      d    = $urandom_range(0, NDUT - 1);
      t    = (1 << NI[d]) * (SI[d] + 1);
      ex   = 16'($urandom);
      mask = ($urandom_range(0, 2) == 0) ? 16'h0 : 16'($urandom) & 16'($urandom);
      launch(d, ex, ex ^ mask, -1);
      if ($urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, t - 1);
        repeat (k) @(posedge clk);
        #1;
        start_a[d]  = 1'b1;
        exp_tt_a[d] = 16'($urandom);
        @(posedge clk); #1;
        start_a[d] = 1'b0;
      end
      wait_idle(d);
    end

    repeat (3) @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gate_sweep_controller.md
# gate_sweep_controller

Sequencer that exhaustively exercises one small combinational gate (inverter, 2-to-4-input AND/OR/XOR, etc.) by stepping its inputs through every vector and checking its output against an expected truth table. Sits beside the gate primitives in the simulation/bring-up area: it drives the gate's inputs, samples its output after a programmable settle time, and reports pass/fail, error count and first failing vector. One run per `start` pulse.

## Interface

Parameters:
- `N_IN`, default 1: gate input count, legal 1..4. Vector count is `NV = 2**N_IN`.
- `SETTLE`, default 1: cycles each vector is held before sampling, legal 1..15.

Ports:
- `clk`: in, 1. Single clock, rising edge.
- `rst`: in, 1. Synchronous, active-high reset.
- `start`: in, 1. Run request; honoured only in IDLE.
- `exp_tt`: in, NV. Expected output; bit i corresponds to vector i. Captured on start acceptance.
- `dut_in`: out, N_IN. Drives the gate-under-test inputs.
- `dut_out`: in, 1. Gate-under-test output.
- `busy`: out, 1. High from the cycle after acceptance through the last SAMPLE cycle.
- `done`: out, 1. One-cycle pulse at run end.
- `pass`: out, 1. 1 when the completed run had zero mismatches.
- `err_count`: out, N_IN+1. Mismatch count for the run, 0..NV.
- `first_fail`: out, N_IN. Index of the first mismatching vector; 0 when `err_count==0`.

## Operation

- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: `busy=0`. When `start=1`, the next edge:
  - latches `exp_tt`;
  - clears `vec`, `dut_in`, `err_count`, `first_fail` and `pass`;
  - loads the settle counter with SETTLE-1;
  - goes to SETTLE.
- SETTLE: `dut_in=vec` is held stable. The settle counter decrements each cycle. At the edge where the counter is 0, the state goes to SAMPLE. SETTLE therefore lasts exactly SETTLE cycles.
- SAMPLE: one cycle. At its closing edge, `dut_out` is compared with `exp_lat[vec]`.
  - On mismatch: `err_count` increments. If `err_count` was 0, `first_fail<=vec`.
  - If `vec==NV-1`, go to DONE. Otherwise `vec` and `dut_in` increment, the settle counter reloads, and the state goes to SETTLE.
- DONE: one cycle.
  - `done=1`.
  - `pass` is set to (`err_count==0`), with the final comparison included.
  - The state then goes to IDLE.
- `start` is ignored in SETTLE, SAMPLE and DONE; it is not queued.
- `pass`, `err_count` and `first_fail` hold from DONE until the next acceptance.
- Changes to `exp_tt` after acceptance have no effect on the run.
- `vec` never wraps. The run terminates at NV-1.
- `err_count` cannot overflow: it is N_IN+1 bits and holds at most NV.

## Timing

- Reset values: state IDLE; `dut_in=0`, `busy=0`, `done=0`, `pass=0`, `err_count=0`, `first_fail=0`.
- `rst` has priority over everything. If asserted mid-run, the next edge returns to IDLE with reset values, and no `done` pulse is produced.
- Let the acceptance edge be edge 0:
  - vector i is driven from edge i*(SETTLE+1) for SETTLE+1 cycles;
  - it is sampled at edge (i+1)*(SETTLE+1);
  - `done` is high for the one cycle following edge NV*(SETTLE+1).
- Worked example, `N_IN=1`, `SETTLE=1`: `done` is high in the cycle after edge 4.
- With `start` held high continuously, a new run is accepted at the first edge in IDLE. This gives one idle cycle between `done` and the next `busy`.
- All outputs are registered. `dut_out` is used only at the SAMPLE closing edge and may be X at other times.

## Structure

- Shared package `gate_sweep_pkg` holds:
  - the state encoding localparams (IDLE=0, SETTLE=1, SAMPLE=2, DONE=3);
  - the legal-range constants for `N_IN` and `SETTLE`.
- The block is flat; no sub-module. The settle counter and vector counter are internal registers.
- Elaboration-time check rejects illegal `N_IN` or `SETTLE` values.

## Test plan

- **Inverter, correct.** `N_IN=1`, `SETTLE=1`, `exp_tt=2'b01`, wired to an inverter. Pulse `start` → `dut_in` is 0 then 1; `done` is high after edge 4; `pass=1`, `err_count=0`, `first_fail=0`.
- **Inverter stuck-at-0.** Same setup, `dut_out` tied 0 → `err_count=1`, `first_fail=0`, `pass=0`.
- **2-input AND.** `N_IN=2`, `SETTLE=3`, `exp_tt=4'b1000`, correct AND → `dut_in` steps 0,1,2,3, each held 4 cycles; `done` after edge 16; `pass=1`.
- **2-input AND miswired as OR.** Same setup → `err_count=2`, `first_fail=1`, `pass=0`.
- **Start/`exp_tt` robustness.**
  - Pulse `start` mid-run → ignored; timing is unchanged.
  - Change `exp_tt` mid-run → ignored.
  - Hold `start` high → back-to-back runs with one IDLE cycle between them.
- **Reset mid-run.** Assert `rst` at edge 2 of a run → all outputs 0 at the next edge; no `done` pulse; a fresh `start` runs normally.
